stft_frame_seq: RTL and testbench

//  Frame-level sequencer for the radar STFT front end. Per frame it clears and runs the mem0->mem1 copy

---
 rtl/stft_frame_seq_pkg.sv | 27 ++
 rtl/stft_frame_seq_if.sv | 27 ++
 rtl/stft_frame_seq_counter.sv | 26 ++
 rtl/stft_frame_seq.sv | 132 +++++++++++++
 tb/tb_stft_frame_seq.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/stft_frame_seq_pkg.sv
// Shared definitions for the STFT frame sequencer: state encoding and default sizing.
// Outputs are registered from the next state, so every output is a pure function of state_t.
package stft_frame_seq_pkg;

   localparam int DEF_NUM_FRAMES = 32;
   localparam int DEF_FRAME_WL   = 8;
   localparam int DEF_COPY_TMO   = 64;
   localparam int DEF_TMO_WL     = 7;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CLR_COPY  = 3'd1,
      ST_COPY      = 3'd2,
      ST_CALC_GO   = 3'd3,
      ST_CALC_WAIT = 3'd4,
      ST_NEXT      = 3'd5,
      ST_FIN       = 3'd6,
      ST_ERR       = 3'd7
   } state_t;

   // FIN is deliberately excluded: busy drops on the same edge done rises.
   function automatic logic is_busy_state(input state_t s);
      return (s == ST_CLR_COPY) || (s == ST_COPY) || (s == ST_CALC_GO) ||
             (s == ST_CALC_WAIT) || (s == ST_NEXT);
   endfunction

endpackage

// File: rtl/stft_frame_seq_if.sv
// Control/handshake bundle between the frame sequencer, its host, the copy unit and the compute engine.
interface stft_frame_seq_if #(
   parameter int FRAME_WL = stft_frame_seq_pkg::DEF_FRAME_WL
);
   logic                clr;
   logic                start;
   logic                busy;
   logic                done;
   logic                err;
   logic                copy_clr;
   logic                copy_en;
   logic                copy_done;
   logic                calc_start;
   logic                calc_done;
   logic                mem0_bank;
   logic [FRAME_WL-1:0] frame_idx;

   modport master (
      output clr, start, copy_done, calc_done,
      input  busy, done, err, copy_clr, copy_en, calc_start, mem0_bank, frame_idx
   );

   modport slave (
      input  clr, start, copy_done, calc_done,
      output busy, done, err, copy_clr, copy_en, calc_start, mem0_bank, frame_idx
   );
endinterface

// File: rtl/stft_frame_seq_counter.sv
// Enable/clear up-counter; clear has priority over enable.
module stft_frame_seq_counter #(
   parameter int WL = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   output logic [WL-1:0] count
);

   logic [WL-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + WL'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/stft_frame_seq.sv
// Frame-level sequencer: per frame clear+run the mem0->mem1 copy, then launch compute and wait,
// ping-ponging the mem0 bank and guarding the copy phase with a timeout.
module stft_frame_seq
   import stft_frame_seq_pkg::*;
#(
   parameter int NUM_FRAMES = DEF_NUM_FRAMES,
   parameter int FRAME_WL   = DEF_FRAME_WL,
   parameter int COPY_TMO   = DEF_COPY_TMO,
   parameter int TMO_WL     = DEF_TMO_WL
) (
   input logic              clk,
   input logic              rst_n,
   stft_frame_seq_if.slave  bus
);

   localparam logic [FRAME_WL-1:0] LAST_IDX = FRAME_WL'(NUM_FRAMES - 1);
   localparam logic [TMO_WL-1:0]   TMO_LAST = TMO_WL'(COPY_TMO - 1);

   state_t              state_reg;
   state_t              state_next;
   logic                start_acc;
   logic                last_frame;
   logic                advance;
   logic [FRAME_WL-1:0] frame_idx;
   logic [TMO_WL-1:0]   tmo_cnt;
   logic                bank_reg;

   logic busy_reg,       busy_next;
   logic done_reg,       done_next;
   logic err_reg,        err_next;
   logic copy_clr_reg,   copy_clr_next;
   logic copy_en_reg,    copy_en_next;
   logic calc_start_reg, calc_start_next;

   assign start_acc  = bus.start && !bus.clr && ((state_reg == ST_IDLE) || (state_reg == ST_ERR));
   assign last_frame = (frame_idx == LAST_IDX);
   // Terminal compare gates the increment, so the index never wraps past the last frame.
   assign advance    = (state_reg == ST_NEXT) && !last_frame;

   stft_frame_seq_counter #(.WL(FRAME_WL)) frame_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.clr || start_acc),
      .en    (advance),
      .count (frame_idx)
   );

   stft_frame_seq_counter #(.WL(TMO_WL)) tmo_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.clr || (state_reg == ST_CLR_COPY)),
      .en    (state_reg == ST_COPY),
      .count (tmo_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_reg <= 1'b0;
      end else if (bus.clr || start_acc) begin
         bank_reg <= 1'b0;
      end else if (advance) begin
         bank_reg <= ~bank_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
         copy_clr_reg   <= 1'b0;
         copy_en_reg    <= 1'b0;
         calc_start_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
         err_reg        <= err_next;
         copy_clr_reg   <= copy_clr_next;
         copy_en_reg    <= copy_en_next;
         calc_start_reg <= calc_start_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      busy_next       = 1'b0;
      done_next       = 1'b0;
      err_next        = 1'b0;
      copy_clr_next   = 1'b0;
      copy_en_next    = 1'b0;
      calc_start_next = 1'b0;

      case (state_reg)
         ST_IDLE, ST_ERR: begin
            if (bus.start) state_next = ST_CLR_COPY;
         end
         // copy_done may still be high from the previous frame here; it is not looked at.
         ST_CLR_COPY: state_next = ST_COPY;
         ST_COPY: begin
            if (bus.copy_done)           state_next = ST_CALC_GO;
            else if (tmo_cnt == TMO_LAST) state_next = ST_ERR;
         end
         ST_CALC_GO: state_next = ST_CALC_WAIT;
         ST_CALC_WAIT: begin
            if (bus.calc_done) state_next = ST_NEXT;
         end
         ST_NEXT: state_next = last_frame ? ST_FIN : ST_CLR_COPY;
         ST_FIN:  state_next = ST_IDLE;
      endcase

      if (bus.clr) state_next = ST_IDLE;

      busy_next       = is_busy_state(state_next);
      done_next       = (state_next == ST_FIN);
      err_next        = (state_next == ST_ERR);
      copy_clr_next   = (state_next == ST_CLR_COPY);
      copy_en_next    = (state_next == ST_COPY);
      calc_start_next = (state_next == ST_CALC_GO);
   end

   assign bus.busy       = busy_reg;
   assign bus.done       = done_reg;
   assign bus.err        = err_reg;
   assign bus.copy_clr   = copy_clr_reg;
   assign bus.copy_en    = copy_en_reg;
   assign bus.calc_start = calc_start_reg;
   assign bus.mem0_bank  = bank_reg;
   assign bus.frame_idx  = frame_idx;

endmodule

// File: tb/tb_stft_frame_seq.sv
// Directed bench for stft_frame_seq: a timeline model builds the expected output waveform per cycle
// from the frame rules; one loop drives scripted inputs and compares every cycle.
module tb_stft_frame_seq;

   localparam int NF   = 3;
   localparam int FWL  = 8;
   localparam int TMO  = 64;
   localparam int TWL  = 7;
   localparam int MAXC = 900;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   stft_frame_seq_if #(.FRAME_WL(FWL)) bus();

   stft_frame_seq #(
      .NUM_FRAMES (NF),
      .FRAME_WL   (FWL),
      .COPY_TMO   (TMO),
      .TMO_WL     (TWL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   bit       i_start[MAXC], i_cdone[MAXC], i_kdone[MAXC], i_clr[MAXC], i_rstn[MAXC];
   bit       e_busy[MAXC], e_done[MAXC], e_err[MAXC], e_cclr[MAXC], e_cen[MAXC], e_cstart[MAXC];
   bit       e_bank[MAXC];
   bit [7:0] e_idx[MAXC];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_int(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic put(input int k, input bit cc, input bit ce, input bit cs);
      e_busy[k] = 1'b1; e_cclr[k] = cc; e_cen[k] = ce; e_cstart[k] = cs;
   endtask

   // Index and bank hold from a frame's first cycle until something later overwrites them.
   task automatic hold_idx(input int k, input int f);
      for (int j = k; j < MAXC; j++) begin
         e_idx[j]  = 8'(f);
         e_bank[j] = f[0];
      end
   endtask

   task automatic abort_from(input int k);
      for (int j = k; j < MAXC; j++) begin
         e_busy[j] = 0; e_done[j] = 0; e_err[j] = 0; e_cclr[j] = 0; e_cen[j] = 0;
         e_cstart[j] = 0; e_bank[j] = 0; e_idx[j] = '0; i_cdone[j] = 0; i_kdone[j] = 0;
      end
   endtask

   // One run: start pulse at s, copy done lc cycles after copy_en rises, calc done lk cycles
   // after calc_start. tmo_frame >= 0 withholds copy_done in that frame. fin = FIN or ERR cycle.
   task automatic run(input int s, input int lc, input int lk, input int tmo_frame, output int fin);
      int  t, a;
      bit  hit;
      i_start[s] = 1'b1;
      t   = s + 1;
      hit = 1'b0;
      fin = 0;
      for (int j = t; j < MAXC; j++) e_err[j] = 1'b0;
      for (int f = 0; f < NF && !hit; f++) begin
         hold_idx(t, f);
         put(t, 1, 0, 0);
         if (f == tmo_frame) begin
            for (int k = t + 1; k <= t + TMO; k++) put(k, 0, 1, 0);
            for (int j = t + TMO + 1; j < MAXC; j++) e_err[j] = 1'b1;
            fin = t + TMO + 1;
            hit = 1'b1;
         end else begin
            for (int k = t + 1; k <= t + 1 + lc; k++) put(k, 0, 1, 0);
            a = t + 2 + lc;
            put(a, 0, 0, 1);
            for (int k = a + 1; k <= a + lk + 1; k++) put(k, 0, 0, 0);
            i_kdone[a + lk] = 1'b1;
            // Copy unit holds done until it sees the next frame's clear.
            for (int k = t + 1 + lc; k <= a + lk + 2; k++) i_cdone[k] = 1'b1;
            t = a + lk + 2;
         end
      end
      if (!hit) begin
         e_done[t] = 1'b1;
         fin = t;
      end
   endtask

   int fin1, fin3, fin4, fin5, fin6, s6, s7, r6, last;
   int done_seen = -1;
   int err_seen  = -1;
   int n_cclr, n_cstart;
   logic [14:0] act_v, exp_v;

   initial begin
      for (int k = 0; k < MAXC; k++) i_rstn[k] = 1'b1;
      for (int k = 0; k < 3; k++)    i_rstn[k] = 1'b0;

      // Frames with stale copy_done levels across CLR_COPY.
      run(5, 40, 10, -1, fin1);
      // Copy timeout in frame 0, then restart.
      run(fin1 + 5, 0, 0, 0, fin3);
      // Copy done lands on the last allowed cycle.
      run(fin3 + 5, 63, 3, -1, fin4);
      // Stray start in CALC_WAIT and stray calc_done in COPY.
      run(fin4 + 5, 20, 8, -1, fin5);
      i_kdone[fin4 + 5 + 6]  = 1'b1;
      i_start[fin4 + 5 + 26] = 1'b1;
      // Async reset mid-COPY of frame 1.
      s6 = fin5 + 5;
      run(s6, 20, 5, -1, fin6);
      r6 = s6 + 40;
      for (int k = r6; k < r6 + 3; k++) i_rstn[k] = 1'b0;
      abort_from(r6);
      // Sync clear mid-CALC_WAIT of frame 1.
      s7 = r6 + 6;
      run(s7, 20, 5, -1, fin6);
      i_clr[s7 + 55] = 1'b1;
      abort_from(s7 + 56);
      last = s7 + 66;

      // Hand-derived anchors for the model itself.
      check_int("model_fin1", fin1, 168);
      check_int("model_err_cycle", fin3, 239);
      n_cclr = 0; n_cstart = 0;
      for (int k = 0; k <= fin1; k++) begin
         n_cclr   += int'(e_cclr[k]);
         n_cstart += int'(e_cstart[k]);
      end
      check_int("model_copy_clr_count", n_cclr, 3);
      check_int("model_calc_start_count", n_cstart, 3);

      bus.start = 0; bus.clr = 0; bus.copy_done = 0; bus.calc_done = 0;
      for (int k = 0; k < last; k++) begin
         @(posedge clk);
         #1;
         rst_n         = i_rstn[k];
         bus.start     = i_start[k];
         bus.clr       = i_clr[k];
         bus.copy_done = i_cdone[k];
         bus.calc_done = i_kdone[k];
         @(negedge clk);
         exp_v = {e_busy[k], e_done[k], e_err[k], e_cclr[k], e_cen[k], e_cstart[k], e_bank[k], e_idx[k]};
         act_v = {bus.busy, bus.done, bus.err, bus.copy_clr, bus.copy_en, bus.calc_start,
                  bus.mem0_bank, bus.frame_idx};
         n_checks++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL outputs cyc=%0d {busy,done,err,cclr,cen,cstart,bank,idx} got %b_%h required %b_%h",
                     k, act_v[14:8], act_v[7:0], exp_v[14:8], exp_v[7:0]);
         end
         if (bus.done === 1'b1 && done_seen < 0) done_seen = k;
         if (bus.err === 1'b1 && err_seen < 0)   err_seen  = k;
         if (i_start[k]) $display("cyc %0d: start pulse, busy=%b err=%b idx=%0d", k, bus.busy, bus.err, bus.frame_idx);
      end

      check_int("dut_first_done_cycle", done_seen, 168);
      check_int("dut_first_err_cycle", err_seen, 239);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
